// File: rtl/led_pattern_gen.sv
// WIDTH-bit LED pattern generator: solid, blink, chase and bounce patterns,
// advanced by a clock-enable prescaler that produces one step every TICK_DIV cycles.
module led_pattern_gen #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             step
);

    localparam int unsigned      CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] LED_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LED_BIT0 = WIDTH'(1);

    typedef enum logic [1:0] {
        MODE_SOLID  = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] led_nxt;
    logic             step_nxt;
    dir_t             dir;
    dir_t             dir_nxt;

    logic             tick;
    logic             one_hot;
    mode_t            mode_sel;
    logic [WIDTH-1:0] pattern_led;
    dir_t             pattern_dir;

    assign mode_sel = mode_t'(mode);
    assign tick     = enable && (cnt == CNT_LAST);
    assign one_hot  = (led != '0) && ((led & (led - LED_BIT0)) == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt  <= '0;
            led  <= '0;
            dir  <= DIR_UP;
            step <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            led  <= led_nxt;
            dir  <= dir_nxt;
            step <= step_nxt;
        end
    end

    // Pattern update applied on a tick, selected by the mode sampled at that edge
    always_comb begin
        pattern_led = led;
        pattern_dir = dir;
        unique case (mode_sel)
            MODE_SOLID: begin
                pattern_led = LED_ONES;
            end
            MODE_BLINK: begin
                pattern_led = (led == LED_ONES) ? '0 : LED_ONES;
            end
            MODE_CHASE: begin
                if (!one_hot) begin
                    pattern_led = LED_BIT0;
                end else begin
                    pattern_led = {led[WIDTH-2:0], led[WIDTH-1]};
                end
            end
            MODE_BOUNCE: begin
                // End LEDs reverse immediately so each end is lit for a single step
                if (!one_hot) begin
                    pattern_led = LED_BIT0;
                    pattern_dir = DIR_UP;
                end else if (dir == DIR_UP) begin
                    if (led[WIDTH-1]) begin
                        pattern_led = led >> 1;
                        pattern_dir = DIR_DOWN;
                    end else begin
                        pattern_led = led << 1;
                    end
                end else begin
                    if (led[0]) begin
                        pattern_led = led << 1;
                        pattern_dir = DIR_UP;
                    end else begin
                        pattern_led = led >> 1;
                    end
                end
            end
            default: begin
                pattern_led = led;
                pattern_dir = dir;
            end
        endcase
    end

    // Next-state: disable > tick > count
    always_comb begin
        cnt_nxt  = cnt;
        led_nxt  = led;
        dir_nxt  = dir;
        step_nxt = 1'b0;
        if (!enable) begin
            cnt_nxt = '0;
            led_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (tick) begin
            cnt_nxt  = '0;
            led_nxt  = pattern_led;
            dir_nxt  = pattern_dir;
            step_nxt = 1'b1;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (WIDTH=8, TICK_DIV=4): expected step values
// and their cycle numbers are queued by the driver and checked by a step monitor.
module tb_led_pattern_gen;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned TICK_DIV = 4;

    typedef struct {
        logic [WIDTH-1:0] led;
        int unsigned      cyc;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic             enable;
    logic [1:0]       mode;
    logic [WIDTH-1:0] led;
    logic             step;

    exp_t        sb_q[$];
    int unsigned cyc;
    int unsigned base;
    int          vectors;
    int          miscompares;

    led_pattern_gen #(
        .WIDTH   (WIDTH),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .mode   (mode),
        .led    (led),
        .step   (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Step monitor: every step pulse must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (step === 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_step: led=%h at cycle %0d, required no step", led, cyc);
                end else begin
                    e = sb_q.pop_front();
                    vectors++;
                    if (led !== e.led) begin
                        miscompares++;
                        $display("FAIL step_led: got %h, required %h (cycle %0d)", led, e.led, cyc);
                    end
                    vectors++;
                    if (cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL step_time: step at cycle %0d, required cycle %0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic push(input logic [WIDTH-1:0] v, input int unsigned c);
        exp_t e;
        e.led = v;
        e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (led !== '0 || step !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: led=%h step=%b, required led=00 step=0 (cycle %0d)", name, led, step, cyc);
        end
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    // Hold reset for 3 edges, then release with enable high; base = release point
    task automatic reset_and_start(input logic [1:0] m);
        @(negedge clk);
        reset_n = 1'b0;
        enable  = 1'b1;
        mode    = m;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        reset_n = 1'b1;
        base    = cyc;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d expected steps never seen", sb_q.size());
            sb_q.delete();
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] chase [9];
        logic [WIDTH-1:0] bounce[16];
        int unsigned nb;
        chase  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        bounce = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        enable      = 1'b0;
        mode        = 2'b00;

        // SOLID: dark for 3 edges, then all ones every 4 cycles
        reset_and_start(2'b00);
        push(8'hFF, base + 4);
        push(8'hFF, base + 8);
        push(8'hFF, base + 12);
        repeat (3) begin
            @(negedge clk);
            check_idle("pre_first_step");
        end
        wait_drain(40);

        // BLINK
        reset_and_start(2'b01);
        push(8'hFF, base + 4);
        push(8'h00, base + 8);
        push(8'hFF, base + 12);
        wait_drain(40);

        // CHASE with wrap from bit 7 to bit 0
        reset_and_start(2'b10);
        for (int i = 0; i < 9; i++) push(chase[i], base + 4 * (i + 1));
        wait_drain(60);

        // BOUNCE with single-step dwell at both ends
        reset_and_start(2'b11);
        for (int i = 0; i < 16; i++) push(bounce[i], base + 4 * (i + 1));
        wait_drain(90);

        // CHASE -> BOUNCE mid-count keeps position, then disable and re-enable
        reset_and_start(2'b10);
        push(8'h01, base + 4);
        push(8'h02, base + 8);
        push(8'h04, base + 12);
        push(8'h08, base + 16);
        wait_cyc(base + 18);
        mode = 2'b11;
        push(8'h10, base + 20);
        push(8'h20, base + 24);
        wait_cyc(base + 26);
        enable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_idle("disable_blank");
        end
        enable = 1'b1;
        push(8'h01, base + 34);
        push(8'h02, base + 38);
        wait_drain(30);

        // Reset pulse in BOUNCE while moving right at 0x20
        reset_and_start(2'b11);
        for (int i = 0; i < 8; i++) push(bounce[i], base + 4 * (i + 1));
        push(8'h40, base + 36);
        push(8'h20, base + 40);
        wait_cyc(base + 41);
        reset_n = 1'b0;
        @(negedge clk);
        check_idle("reset_pulse");
        reset_n = 1'b1;
        nb = cyc;
        push(8'h01, nb + 4);
        push(8'h02, nb + 8);
        push(8'h04, nb + 12);
        wait_drain(30);

        repeat (6) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator. It is the successor to the single-pattern enable-driven blinker. It folds the slow-clock divider into a clock-enable prescaler, so all logic runs on `clk`. It drives a `WIDTH`-bit LED bank in one of four run-time-selectable patterns: solid, blink, chase and bounce. It sits between the board switches (`enable`, `mode`) and the LED pins, and exports a step strobe for other blocks to synchronise to.

## Interface
- `WIDTH`, 16: number of LEDs. Legal range is ≥ 2.
- `TICK_DIV`, 50_000_000: `clk` cycles per pattern step. Legal range is ≥ 2. Benches use small values.

- `clk`  in  1: system clock. All state updates on the rising edge.
- `reset_n`  in  1: reset. Synchronous and active-low: it is sampled only on the rising edge of `clk`, and low means reset.
- `enable`  in  1: run enable. Low blanks the LEDs and holds the prescaler.
- `mode`  in  2: pattern select. 00 = SOLID, 01 = BLINK, 10 = CHASE, 11 = BOUNCE.
- `led`  out  `WIDTH`: LED drive. Registered, and 1 = lit.
- `step`  out  1: one-cycle strobe, high in the cycle `led` takes a step update.

## Operation
- State:
  - prescaler `cnt`, width `$clog2(TICK_DIV)`
  - `led` register
  - `dir` bit (0 = left/up toward MSB, 1 = right)
  - `step` register
- Priority per edge: `reset_n` low > `enable` low > tick > hold.
- Reset (`reset_n`=0 at edge): `cnt`=0, `led`=0, `dir`=0, `step`=0.
- `enable`=0: `cnt`←0, `led`←0, `dir`←0, `step`←0. This takes effect on the next edge, regardless of `mode`.
- `enable`=1, no tick: `cnt`←`cnt`+1, and `led`, `dir` hold, and `step`←0.
- Tick condition: `enable`=1 and `cnt`==`TICK_DIV`-1.
  - `cnt`←0 (wrap).
  - `step`←1.
  - `led` is updated according to the current `mode`, sampled on the tick edge.
- One-hot test `oh` means `led` has exactly one bit set. The value 0 is not one-hot.
- Update per mode on a tick:
  - SOLID: `led`←all ones.
  - BLINK: if `led`==all ones, then `led`←0. Otherwise `led`←all ones. A non-uniform value therefore goes to all ones first.
  - CHASE: if not `oh`, then `led`←1 (bit 0). Otherwise rotate left by 1, with bit `WIDTH`-1 wrapping to bit 0.
  - BOUNCE:
    - If not `oh`: `led`←1 and `dir`←0.
    - Else if `dir`=0: if `led[WIDTH-1]`, then `led`←`led`>>1 and `dir`←1. Otherwise `led`←`led`<<1.
    - Else (`dir`=1): if `led[0]`, then `led`←`led`<<1 and `dir`←0. Otherwise `led`←`led`>>1.
    - The end LEDs are lit for one step only, with no double dwell.
- `dir` is written only in BOUNCE (and by reset or disable). Other modes leave it unchanged.
- `mode` changes take effect only at the next tick. The prescaler is not restarted.
  - CHASE to BOUNCE keeps the lit position and the stored `dir`.
  - SOLID to CHASE or BOUNCE restarts at bit 0.

## Timing
- After reset release with `enable`=1 held, the first `led` update occurs on the `TICK_DIV`-th rising edge at which `enable` is sampled high. Subsequent updates occur every `TICK_DIV` cycles exactly.
- `step` is high for exactly one cycle, coincident with the new `led` value. Its period is `TICK_DIV`.
- When `enable` falls, `led` reads 0 one cycle after the sampling edge. When `enable` rises again, the count restarts from 0.
- `reset_n` asserted mid-step discards the partial count. Outputs read 0 from the cycle after the sampling edge.
- No combinational path exists from the inputs to the outputs.

## Test plan
Parameters for all scenarios: `WIDTH`=8, `TICK_DIV`=4.
- Reset and first step: hold `reset_n`=0 for 3 cycles, then release with `enable`=1 and `mode`=00.
  - `led`=0x00 and `step`=0 until edge 4 after release.
  - Then `led`=0xFF and `step`=1 for 1 cycle.
  - `step` pulses again every 4 cycles.
- BLINK: with `mode`=01 from reset, `led` takes the sequence 0xFF, 0x00, 0xFF at steps 1, 2, 3 (every 4 cycles).
- CHASE wrap: with `mode`=10, `led` takes the sequence 0x01, 0x02, … 0x80, 0x01 over 9 steps.
- BOUNCE ends: with `mode`=11, `led` takes the sequence 0x01, 0x02, … 0x80, 0x40, … 0x01, 0x02.
  - 0x80 and 0x01 each appear once per turn.
- Mid-run events:
  - In CHASE at `led`=0x08, switch `mode` to 11 two cycles before a tick. The next step gives 0x10.
  - Deassert `enable` mid-count. `led` reads 0x00 on the next cycle and `step` stays 0. On re-enable, the next step comes 4 cycles later with `led`=0x01.
- Reset mid-operation: in BOUNCE with `dir`=1 at `led`=0x20, pulse `reset_n` low for 1 cycle while `enable`=1.
  - `led`=0x00 in the cycle after the reset edge.
  - After release, the sequence restarts at 0x01 and moves left.
